mfcc_frame_sequencer: RTL and testbench
=======================================

// Module: mfcc_frame_sequencer
// PURPOSE
//  Per-frame controller for the MFCC front end: window_buffer -> Hamming_Window -> FFT -> power bank -> mel stage.
//  Issues stage start pulses and waits for each stage's done. Owns the 2-bank ping-pong power buffer (FFT writes one bank, mel reads the other).
//  Counts frames, guards every wait with a watchdog, and replaces the direct start_next_state_o->start_i and hamming done->FFT start wiring.
// PARAMETERS
//  FRAME_CNT_WIDTH  16      width of frame counter / num_frames_i
//  TIMEOUT_CYCLES   4096    max cycles in any wait state before error
//  TMO_WIDTH        $clog2(TIMEOUT_CYCLES+1)  watchdog width
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   async active-low reset
//  enable_i         in   1   level; 0->1 edge in IDLE starts a run
//  num_frames_i     in   FCW frames per run; 0 = run until enable_i drops; sampled at run start
//  window_ready_i   in   1   window_buffer.start_next_state_o (frame available)
//  start_move_o     out  1   1-cycle pulse: window_buffer slides by MOVE_SIZE
//  hamming_start_o  out  1   1-cycle pulse to Hamming_Window.start_i
//  hamming_done_i   in   1   Hamming_Window.done_o
//  fft_start_o      out  1   1-cycle pulse to FFT.start_i
//  fft_done_i       in   1   FFT.fft_done_o
//  fft_bank_o       out  1   power bank FFT writes into
//  mel_start_o      out  1   1-cycle pulse: mel stage may read mel_bank_o
//  mel_bank_o       out  1   bank handed to mel stage (valid with mel_start_o)
//  mel_done_i       in   1   mel stage finished its bank
//  frame_cnt_o      out  FCW frames completed through FFT this run
//  frame_done_o     out  1   1-cycle pulse per completed FFT frame
//  busy_o           out  1   state != IDLE
//  error_o          out  1   sticky watchdog error
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, both banks free, fft_bank_o=0, watchdog 0.
//  States: IDLE -> WAIT_WIN -> HAMM -> WAIT_BANK -> FFT -> MOVE -> (WAIT_WIN | DONE); ERROR.
//  IDLE: enable_i rising edge -> latch num_frames_i, frame_cnt_o<=0, clear error_o -> WAIT_WIN.
//  WAIT_WIN: window_ready_i=1 -> hamming_start_o=1 next cycle -> HAMM.
//  HAMM: wait hamming_done_i -> WAIT_BANK.
//  WAIT_BANK: bank fft_bank_o free -> fft_start_o=1 next cycle -> FFT. Otherwise stall; watchdog runs.
//  FFT: fft_done_i -> mark fft_bank_o full; mel_start_o=1 + mel_bank_o=fft_bank_o same cycle;
//   toggle fft_bank_o; frame_cnt_o+1; frame_done_o=1 -> MOVE.
//  MOVE: start_move_o=1 for one cycle. Next: DONE if frame_cnt_o==latched N (N!=0) or enable_i=0; else WAIT_WIN.
//  DONE: wait until both banks free (mel drained) -> IDLE. Re-arm requires enable_i to fall and rise again.
//  Bank release: mel_done_i frees the bank last handed out (oldest outstanding; FIFO order, max 2).
//   fft_done_i and mel_done_i in same cycle: both take effect; the freed bank is not the one just filled.
//   mel_done_i with no bank full: ignored.
//  Start outputs are registered, exactly 1 cycle each, never overlapping. done inputs outside the matching wait state are ignored.
//  Latency: window_ready_i -> hamming_start_o 1 cycle; hamming_done_i -> fft_start_o 1 cycle when bank free;
//   fft_done_i -> mel_start_o/frame_done_o 0 cycles (combinational from registered state+input is NOT allowed: registered, 1 cycle).
//  Watchdog: clears on every state entry, counts in WAIT_WIN/HAMM/WAIT_BANK/FFT/DONE;
//   at TIMEOUT_CYCLES -> error_o=1, state ERROR.
//  ERROR: no pulses issued; enable_i=0 -> IDLE; banks reset free; fft_bank_o=0.
//  enable_i=0 mid-frame: current frame completes, then DONE (no abort of FFT).
//  Async reset mid-operation: immediate return to reset values; in-flight stage done pulses after reset are ignored.
//  frame_cnt_o saturates at all-ones (no wrap).
// STRUCTURE
//  Package mfcc_pkg: typedef enum logic [2:0] seq_state_t
//   {IDLE,WAIT_WIN,HAMM,WAIT_BANK,FFT,MOVE,DONE,ERROR}; localparam NUM_POWER_BANKS=2.
//  One sub-module: pingpong_bank_tracker (full flags, fill/read pointers, fill/release handshake).
//  Watchdog and FSM inline.
// TESTING
//  1 num_frames_i=3, instant mel_done 5 cycles after mel_start ->
//    3 hamming/fft/move pulses, frame_cnt_o=3, fft_bank_o seq 0,1,0, back to IDLE.
//  2 mel_done_i withheld after 2 frames, N=4 ->
//    3rd fft_start_o stalls in WAIT_BANK; mel_done_i releases bank 0; fft_start_o 1 cycle later.
//  3 fft_done_i and mel_done_i same cycle ->
//    bank filled stays full, other bank freed, no missed or extra mel_start_o.
//  4 TIMEOUT_CYCLES=64, hamming_done_i never asserts ->
//    error_o=1 at cycle 64 in HAMM; no further pulses; enable_i=0 -> IDLE, error_o clears on next run.
//  5 num_frames_i=0, drop enable_i during FFT ->
//    frame completes, start_move_o issued, DONE waits mel drain, then IDLE.
//  6 rst_n low during FFT state ->
//    all outputs 0 immediately; stale fft_done_i after release ignored in IDLE.

Source files
------------

// File: rtl/mfcc_pkg.sv
// Shared types and constants for the MFCC per-frame sequencer.
package mfcc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WIN,
    HAMM,
    WAIT_BANK,
    FFT,
    MOVE,
    DONE,
    ERROR
  } seq_state_t;

  localparam int unsigned NUM_POWER_BANKS = 2;

endpackage

// File: rtl/pingpong_bank_tracker.sv
// Two-bank ping-pong power buffer bookkeeping: FFT fills banks in order, the mel stage
// releases them in the same order (oldest outstanding first).
module pingpong_bank_tracker
  import mfcc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic fill_i,
  input  logic release_i,
  output logic fill_bank_o,
  output logic fill_free_o,
  output logic all_free_o
);

  logic [NUM_POWER_BANKS-1:0] full_q, full_d;
  logic                       wr_ptr_q, wr_ptr_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic                       rel_ok;

  // A release with nothing outstanding is dropped.
  assign rel_ok = release_i && full_q[rd_ptr_q];

  always_comb begin
    full_d   = full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (rel_ok) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end
    if (fill_i) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else if (clear_i) begin
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // A same-cycle release of the fill bank counts as free so the FFT can start a cycle earlier.
  assign fill_free_o = !full_q[wr_ptr_q] || (rel_ok && (rd_ptr_q == wr_ptr_q));
  assign all_free_o  = ~|full_q;
  assign fill_bank_o = wr_ptr_q;

endmodule

// File: rtl/mfcc_frame_sequencer.sv
// Per-frame controller for the MFCC front end: sequences window/Hamming/FFT/mel stages,
// owns the ping-pong power buffer, counts frames and guards every wait with a watchdog.
module mfcc_frame_sequencer
  import mfcc_pkg::*;
#(
  parameter int unsigned FRAME_CNT_WIDTH = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  parameter int unsigned TMO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable_i,
  input  logic [FRAME_CNT_WIDTH-1:0] num_frames_i,
  input  logic                       window_ready_i,
  output logic                       start_move_o,
  output logic                       hamming_start_o,
  input  logic                       hamming_done_i,
  output logic                       fft_start_o,
  input  logic                       fft_done_i,
  output logic                       fft_bank_o,
  output logic                       mel_start_o,
  output logic                       mel_bank_o,
  input  logic                       mel_done_i,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o,
  output logic                       frame_done_o,
  output logic                       busy_o,
  output logic                       error_o
);

  seq_state_t                 state_q;
  logic                       enable_q;
  logic [FRAME_CNT_WIDTH-1:0] num_frames_q;
  logic [TMO_WIDTH-1:0]       tmo_q;
  logic                       tmo_expired;
  logic                       fill_free;
  logic                       all_free;
  logic                       bank_fill;
  logic                       bank_clear;

  assign tmo_expired = (tmo_q == TMO_WIDTH'(TIMEOUT_CYCLES - 1));
  assign bank_fill   = (state_q == FFT) && fft_done_i;
  assign bank_clear  = (state_q == ERROR) && !enable_i;
  assign busy_o      = (state_q != IDLE);

  pingpong_bank_tracker u_banks (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (bank_clear),
    .fill_i      (bank_fill),
    .release_i   (mel_done_i),
    .fill_bank_o (fft_bank_o),
    .fill_free_o (fill_free),
    .all_free_o  (all_free)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      enable_q        <= 1'b0;
      num_frames_q    <= '0;
      tmo_q           <= '0;
      start_move_o    <= 1'b0;
      hamming_start_o <= 1'b0;
      fft_start_o     <= 1'b0;
      mel_start_o     <= 1'b0;
      mel_bank_o      <= 1'b0;
      frame_cnt_o     <= '0;
      frame_done_o    <= 1'b0;
      error_o         <= 1'b0;
    end else begin
      enable_q        <= enable_i;
      start_move_o    <= 1'b0;
      hamming_start_o <= 1'b0;
      fft_start_o     <= 1'b0;
      mel_start_o     <= 1'b0;
      frame_done_o    <= 1'b0;
      // Every transition below resets the watchdog; waiting states just keep counting.
      tmo_q           <= tmo_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (enable_i && !enable_q) begin
            num_frames_q <= num_frames_i;
            frame_cnt_o  <= '0;
            error_o      <= 1'b0;
            state_q      <= WAIT_WIN;
          end
        end
        WAIT_WIN: begin
          if (window_ready_i) begin
            hamming_start_o <= 1'b1;
            tmo_q           <= '0;
            state_q         <= HAMM;
          end else if (tmo_expired) begin
            error_o <= 1'b1;
            tmo_q   <= '0;
            state_q <= ERROR;
          end
        end
        HAMM: begin
          if (hamming_done_i) begin
            tmo_q <= '0;
            if (fill_free) begin
              fft_start_o <= 1'b1;
              state_q     <= FFT;
            end else begin
              state_q <= WAIT_BANK;
            end
          end else if (tmo_expired) begin
            error_o <= 1'b1;
            tmo_q   <= '0;
            state_q <= ERROR;
          end
        end
        WAIT_BANK: begin
          if (fill_free) begin
            fft_start_o <= 1'b1;
            tmo_q       <= '0;
            state_q     <= FFT;
          end else if (tmo_expired) begin
            error_o <= 1'b1;
            tmo_q   <= '0;
            state_q <= ERROR;
          end
        end
        FFT: begin
          if (fft_done_i) begin
            mel_start_o  <= 1'b1;
            mel_bank_o   <= fft_bank_o;
            frame_done_o <= 1'b1;
            if (frame_cnt_o != '1) frame_cnt_o <= frame_cnt_o + 1'b1;
            tmo_q   <= '0;
            state_q <= MOVE;
          end else if (tmo_expired) begin
            error_o <= 1'b1;
            tmo_q   <= '0;
            state_q <= ERROR;
          end
        end
        MOVE: begin
          start_move_o <= 1'b1;
          tmo_q        <= '0;
          if (((num_frames_q != '0) && (frame_cnt_o == num_frames_q)) || !enable_i) begin
            state_q <= DONE;
          end else begin
            state_q <= WAIT_WIN;
          end
        end
        DONE: begin
          if (all_free) begin
            tmo_q   <= '0;
            state_q <= IDLE;
          end else if (tmo_expired) begin
            error_o <= 1'b1;
            tmo_q   <= '0;
            state_q <= ERROR;
          end
        end
        ERROR: begin
          tmo_q <= '0;
          if (!enable_i) state_q <= IDLE;
        end
        default: begin
          tmo_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mfcc_frame_sequencer.sv
// Bench for mfcc_frame_sequencer: table-driven and randomized runs with auto-responding stages,
// a queue-based bank/frame scoreboard, and hand-driven corner-case sequences.
module tb_mfcc_frame_sequencer;

  localparam int unsigned FCW = 16;
  localparam int unsigned TMO = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable_i = 1'b0;
  logic [FCW-1:0] num_frames_i = '0;
  wire            window_ready_i, hamming_done_i, fft_done_i, mel_done_i;
  logic           start_move_o, hamming_start_o, fft_start_o, fft_bank_o;
  logic           mel_start_o, mel_bank_o, frame_done_o, busy_o, error_o;
  logic [FCW-1:0] frame_cnt_o;

  // Stage inputs come either from the auto responder (a_*) or from hand sequences (m_*).
  logic auto_en = 1'b0;
  logic a_win = 1'b0, a_ham = 1'b0, a_fft = 1'b0, a_mel = 1'b0;
  logic m_win = 1'b0, m_ham = 1'b0, m_fft = 1'b0, m_mel = 1'b0;
  assign window_ready_i = auto_en ? a_win : m_win;
  assign hamming_done_i = auto_en ? a_ham : m_ham;
  assign fft_done_i     = auto_en ? a_fft : m_fft;
  assign mel_done_i     = auto_en ? a_mel : m_mel;

  mfcc_frame_sequencer #(
    .FRAME_CNT_WIDTH (FCW),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable_i        (enable_i),
    .num_frames_i    (num_frames_i),
    .window_ready_i  (window_ready_i),
    .start_move_o    (start_move_o),
    .hamming_start_o (hamming_start_o),
    .hamming_done_i  (hamming_done_i),
    .fft_start_o     (fft_start_o),
    .fft_done_i      (fft_done_i),
    .fft_bank_o      (fft_bank_o),
    .mel_start_o     (mel_start_o),
    .mel_bank_o      (mel_bank_o),
    .mel_done_i      (mel_done_i),
    .frame_cnt_o     (frame_cnt_o),
    .frame_done_o    (frame_done_o),
    .busy_o          (busy_o),
    .error_o         (error_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- scoreboard: banks handed to mel in FIFO order ----------------
  int   occ[$];
  int   exp_bank = 0;
  int   exp_cnt = 0;
  int   phase = 0;
  int   n_ham = 0, n_fft = 0, n_move = 0, n_mel = 0;
  logic busy_prev = 1'b0;
  logic rel_seen = 1'b0;

  always @(posedge clk) rel_seen <= mel_done_i && rst_n;

  always @(negedge clk) begin
    if (!rst_n) begin
      occ.delete();
      exp_bank  = 0;
      exp_cnt   = 0;
      phase     = 0;
      busy_prev = 1'b0;
    end else begin
      if (busy_o && !busy_prev) begin
        exp_cnt = 0;
        phase   = 0;
        n_ham = 0; n_fft = 0; n_move = 0; n_mel = 0;
      end
      if (!busy_o && busy_prev && error_o) begin
        occ.delete();
        exp_bank = 0;
      end
      if (rel_seen && occ.size() > 0) void'(occ.pop_front());
      if (hamming_start_o) begin
        check("order hamming_start", phase, 0);
        phase = 1;
        n_ham++;
      end
      if (fft_start_o) begin
        int busy_bank;
        busy_bank = 0;
        foreach (occ[i]) if (occ[i] == exp_bank) busy_bank = 1;
        check("order fft_start", phase, 1);
        check("fft_start bank", fft_bank_o, exp_bank);
        check("fft_start into free bank", busy_bank, 0);
        phase = 2;
        n_fft++;
      end
      if (mel_start_o) begin
        check("mel_bank", mel_bank_o, exp_bank);
        occ.push_back(exp_bank);
        exp_bank = 1 - exp_bank;
        if (exp_cnt != 65535) exp_cnt++;
        check("frame_done with mel_start", frame_done_o, 1);
        check("frame_cnt", frame_cnt_o, exp_cnt);
        n_mel++;
      end
      if (start_move_o) begin
        check("order start_move", phase, 2);
        phase = 0;
        n_move++;
      end
      busy_prev = busy_o;
    end
  end

  // ---------------- auto responder: random stage latencies ----------------
  int cyc = 0;
  int ham_cd = 0, fft_cd = 0;
  int mel_dly = 5;
  int mel_due[$];

  always @(negedge clk) begin
    if (auto_en) begin
      cyc++;
      a_win = ($urandom_range(0, 1) == 1);
      a_ham = 1'b0;
      a_fft = 1'b0;
      a_mel = 1'b0;
      if (hamming_start_o) ham_cd = $urandom_range(1, 4);
      if (ham_cd > 0) begin
        ham_cd--;
        if (ham_cd == 0) a_ham = 1'b1;
      end
      if (fft_start_o) fft_cd = $urandom_range(1, 4);
      if (fft_cd > 0) begin
        fft_cd--;
        if (fft_cd == 0) a_fft = 1'b1;
      end
      if (mel_start_o) mel_due.push_back(cyc + ((mel_dly == 0) ? $urandom_range(1, 12) : mel_dly));
      if (mel_due.size() > 0 && mel_due[0] <= cyc) begin
        a_mel = 1'b1;
        void'(mel_due.pop_front());
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    auto_en = 1'b0;
    enable_i = 1'b0;
    m_win = 1'b0; m_ham = 1'b0; m_fft = 1'b0; m_mel = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0:       return hamming_start_o;
      4:       return !busy_o;
      default: return error_o;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int budget, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = sig_of(which);
    end
    check({name, " within budget"}, seen, 1);
  endtask

  task automatic run_auto(input int n, input int dly, input int drop_at);
    do_reset();
    ham_cd = 0; fft_cd = 0; cyc = 0;
    mel_due.delete();
    mel_dly = dly;
    num_frames_i = FCW'(n);
    auto_en = 1'b1;
    @(negedge clk);
    enable_i = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (drop_at != 0 && n_fft == drop_at) enable_i = 1'b0;
      if (!busy_o && i > 2) break;
    end
    check("run returns to IDLE", busy_o, 0);
    auto_en = 1'b0;
  endtask

  // Hand-driven frame up to the FFT start; stall_cycles > 0 expects a bank stall then releases.
  task automatic frame_to_fft(input int exp_bnk, input int stall_cycles);
    m_win = 1'b1;
    wait_sig(0, 40, "hamming_start");
    m_win = 1'b0;
    m_ham = 1'b1;
    @(negedge clk);
    m_ham = 1'b0;
    if (stall_cycles > 0) begin
      for (int i = 0; i < stall_cycles; i++) begin
        check("fft_start held while bank full", fft_start_o, 0);
        @(negedge clk);
      end
      m_mel = 1'b1;
      @(negedge clk);
      m_mel = 1'b0;
    end
    check("fft_start one cycle after go", fft_start_o, 1);
    check("fft_bank at start", fft_bank_o, exp_bnk);
  endtask

  task automatic frame_finish(input logic mel_same, input int exp_bnk, input int cnt);
    m_fft = 1'b1;
    m_mel = mel_same;
    @(negedge clk);
    m_fft = 1'b0;
    m_mel = 1'b0;
    check("mel_start after fft_done", mel_start_o, 1);
    check("mel_bank handed out", mel_bank_o, exp_bnk);
    check("frame_done pulse", frame_done_o, 1);
    check("frame_cnt after frame", frame_cnt_o, cnt);
    @(negedge clk);
    check("start_move after frame", start_move_o, 1);
    check("single mel_start", mel_start_o, 0);
  endtask

  typedef struct {
    int   n;
    int   dly;
    int   drop_at;
    int   exp_frames;
    logic exp_bank;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int total_before;
    #30000000;
    $display("FAIL global time limit reached");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int pulses;
    vecs[0] = '{3, 5, 0, 3, 1'b1};
    vecs[1] = '{1, 1, 0, 1, 1'b1};
    vecs[2] = '{4, 20, 0, 4, 1'b0};
    vecs[3] = '{5, 0, 0, 5, 1'b1};
    vecs[4] = '{2, 3, 0, 2, 1'b0};
    vecs[5] = '{0, 4, 3, 3, 1'b1};
    vecs[6] = '{6, 2, 2, 2, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset outputs", {start_move_o, hamming_start_o, fft_start_o, fft_bank_o, mel_start_o,
                            mel_bank_o, frame_done_o, busy_o, error_o, frame_cnt_o}, 0);
    rst_n = 1'b1;

    // Table-driven runs
    for (int v = 0; v < 7; v++) begin
      run_auto(vecs[v].n, vecs[v].dly, vecs[v].drop_at);
      check("mel_start count", n_mel, vecs[v].exp_frames);
      check("hamming_start count", n_ham, vecs[v].exp_frames);
      check("fft_start count", n_fft, vecs[v].exp_frames);
      check("start_move count", n_move, vecs[v].exp_frames);
      check("final frame_cnt", frame_cnt_o, vecs[v].exp_frames);
      check("final fft_bank", fft_bank_o, vecs[v].exp_bank);
      check("no error", error_o, 0);
    end

    // Randomized runs against the scoreboard
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 6);
      run_auto(n, 0, 0);
      check("rand frames", n_mel, n);
      check("rand frame_cnt", frame_cnt_o, n);
      check("rand fft_bank parity", fft_bank_o, n % 2);
      check("rand no error", error_o, 0);
    end

    // Withheld mel_done: third FFT stalls until bank 0 is released
    do_reset();
    num_frames_i = 4;
    enable_i = 1'b1;
    frame_to_fft(0, 0); frame_finish(1'b0, 0, 1);
    frame_to_fft(1, 0); frame_finish(1'b0, 1, 2);
    frame_to_fft(0, 5); frame_finish(1'b0, 0, 3);

    // fft_done and mel_done together; release order is oldest-first
    do_reset();
    num_frames_i = 0;
    enable_i = 1'b1;
    frame_to_fft(0, 0); frame_finish(1'b0, 0, 1);
    frame_to_fft(1, 0); frame_finish(1'b1, 1, 2);
    frame_to_fft(0, 0); frame_finish(1'b0, 0, 3);
    frame_to_fft(1, 3);
    enable_i = 1'b0;
    frame_finish(1'b0, 1, 4);
    repeat (3) @(negedge clk);
    check("DONE waits for mel drain", busy_o, 1);
    m_mel = 1'b1; @(negedge clk); m_mel = 1'b0; @(negedge clk);
    m_mel = 1'b1; @(negedge clk); m_mel = 1'b0;
    wait_sig(4, 10, "IDLE after drain");
    check("drain frame_cnt", frame_cnt_o, 4);

    // Watchdog in HAMM
    do_reset();
    num_frames_i = 1;
    enable_i = 1'b1;
    m_win = 1'b1;
    wait_sig(0, 20, "hamming_start before timeout");
    m_win = 1'b0;
    repeat (63) @(negedge clk);
    check("no error before timeout", error_o, 0);
    pulses = n_ham + n_fft + n_move + n_mel;
    @(negedge clk);
    check("error at timeout", error_o, 1);
    check("busy in ERROR", busy_o, 1);
    m_ham = 1'b1; @(negedge clk); m_ham = 1'b0;
    m_fft = 1'b1; @(negedge clk); m_fft = 1'b0;
    repeat (6) @(negedge clk);
    check("no pulses in ERROR", n_ham + n_fft + n_move + n_mel, pulses);
    enable_i = 1'b0;
    repeat (2) @(negedge clk);
    check("ERROR exits to IDLE", busy_o, 0);
    check("error sticky in IDLE", error_o, 1);
    enable_i = 1'b1;
    @(negedge clk);
    check("error clears on new run", error_o, 0);
    check("new run busy", busy_o, 1);

    // Async reset during FFT; stale fft_done afterwards is ignored
    do_reset();
    num_frames_i = 0;
    enable_i = 1'b1;
    frame_to_fft(0, 0); frame_finish(1'b0, 0, 1);
    frame_to_fft(1, 0);
    check("busy before reset", busy_o, 1);
    rst_n = 1'b0;
    enable_i = 1'b0;
    m_fft = 1'b1;
    #1;
    check("outputs cleared by async reset",
          {start_move_o, hamming_start_o, fft_start_o, fft_bank_o, mel_start_o, mel_bank_o,
           frame_done_o, busy_o, error_o, frame_cnt_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_fft = 1'b0;
    check("stale fft_done: no mel_start", mel_start_o, 0);
    check("stale fft_done: no frame_done", frame_done_o, 0);
    check("stale fft_done: still IDLE", busy_o, 0);
    @(negedge clk);
    check("stale fft_done: frame_cnt", frame_cnt_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
